// File: rtl/cdc_hs_rx_if.sv
// Bundle between the toggle-handshake source, the local consumer and cdc_hs_rx.
// master = source + consumer side, slave = cdc_hs_rx.
interface cdc_hs_rx_if #(
   parameter int unsigned D_WIDTH = 32
);
   logic               req_s;
   logic [D_WIDTH-1:0] data_s;
   logic               ack_d;
   logic               dout_valid;
   logic               dout_ready;
   logic [D_WIDTH-1:0] dout_data;
   logic               busy;

   modport master (
      output req_s, data_s, dout_ready,
      input  ack_d, dout_valid, dout_data, busy
   );

   modport slave (
      input  req_s, data_s, dout_ready,
      output ack_d, dout_valid, dout_data, busy
   );
endinterface

// File: rtl/cdc_hs_rx.sv
// Destination side of a two-phase req/ack CDC handshake: syncs req_s, captures data_s,
// presents it on valid/ready and toggles ack_d on acceptance. Option: CDC_HS_RX_ERR_EN.
module cdc_hs_rx #(
   parameter int unsigned       D_WIDTH      = 32,
   parameter bit                DELAY_2      = 1'b1,
   parameter logic [D_WIDTH-1:0] DATA_DEFAULT = '0
) (
   input  logic        clk_d,
   input  logic        rst_d_n,
   cdc_hs_rx_if.slave  bus
`ifdef CDC_HS_RX_ERR_EN
   ,
   input  logic        err_clr,
   output logic        proto_err
`endif
);

   localparam int unsigned SYNC_LEN = DELAY_2 ? 2 : 3;

   typedef enum logic {IDLE = 1'b0, VALID = 1'b1} state_e;

   state_e               state_q, state_d;
   logic [SYNC_LEN-1:0]  sync_q, sync_d;
   logic                 req_last_q, req_last_d;
   logic                 ack_q, ack_d_nxt;
   logic                 dout_valid_q, dout_valid_d;
   logic [D_WIDTH-1:0]   dout_data_q, dout_data_d;
   logic                 busy_q, busy_d;
   logic                 req_sync;
   logic                 new_req;

   assign sync_d   = {sync_q[SYNC_LEN-2:0], bus.req_s};
   assign req_sync = sync_q[SYNC_LEN-1];
   assign new_req  = req_sync ^ req_last_q;

   // State register and all datapath flops
   always_ff @(posedge clk_d or negedge rst_d_n) begin
      if (!rst_d_n) begin
         state_q      <= IDLE;
         sync_q       <= '0;
         req_last_q   <= 1'b0;
         ack_q        <= 1'b0;
         dout_valid_q <= 1'b0;
         dout_data_q  <= DATA_DEFAULT;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         sync_q       <= sync_d;
         req_last_q   <= req_last_d;
         ack_q        <= ack_d_nxt;
         dout_valid_q <= dout_valid_d;
         dout_data_q  <= dout_data_d;
         busy_q       <= busy_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (new_req)        state_d = VALID;
         VALID:   if (bus.dout_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output / datapath next values; data_s is safe to sample once req has been synchronised
   always_comb begin
      req_last_d   = req_last_q;
      ack_d_nxt    = ack_q;
      dout_valid_d = dout_valid_q;
      dout_data_d  = dout_data_q;
      busy_d       = busy_q;
      case (state_q)
         IDLE: begin
            if (new_req) begin
               dout_data_d  = bus.data_s;
               req_last_d   = req_sync;
               dout_valid_d = 1'b1;
               busy_d       = 1'b1;
            end
         end
         VALID: begin
            if (bus.dout_ready) begin
               dout_valid_d = 1'b0;
               busy_d       = 1'b0;
               ack_d_nxt    = ~ack_q;
            end
         end
         default: begin
            dout_valid_d = 1'b0;
            busy_d       = 1'b0;
         end
      endcase
   end

   assign bus.ack_d      = ack_q;
   assign bus.dout_valid = dout_valid_q;
   assign bus.dout_data  = dout_data_q;
   assign bus.busy       = busy_q;

`ifdef CDC_HS_RX_ERR_EN
   logic req_sync_q;
   logic proto_err_q, proto_err_d;

   // Sticky flag: req moved while a word was still unacknowledged; set beats clear
   always_comb begin
      proto_err_d = proto_err_q;
      if (err_clr) proto_err_d = 1'b0;
      if (state_q == VALID && req_sync != req_sync_q) proto_err_d = 1'b1;
   end

   always_ff @(posedge clk_d or negedge rst_d_n) begin
      if (!rst_d_n) begin
         req_sync_q  <= 1'b0;
         proto_err_q <= 1'b0;
      end else begin
         req_sync_q  <= req_sync;
         proto_err_q <= proto_err_d;
      end
   end

   assign proto_err = proto_err_q;
`endif

endmodule
